// File: rtl/rx_drop_stat_pkg.sv
// Shared types and constants for the RX drop statistics block.
package rx_drop_stat_pkg;

    localparam int DEF_CNT_W = 48;
    localparam int DEF_ACC_W = 8;

    typedef logic [DEF_CNT_W-1:0] cnt_t;
    typedef logic [DEF_ACC_W-1:0] acc_t;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic SEL_TOTAL = 1'b0;
    localparam logic SEL_DROP  = 1'b1;

endpackage

// File: rtl/rx_drop_rr_sched.sv
// Round-robin grant over per-port request bits; one grant per cycle, pointer kept inside.
// Latency: combinational grant; backpressure: en_i low suppresses the grant and holds the pointer.
module rx_drop_rr_sched #(
    parameter int PORTS  = 2,
    parameter int PIDX_W = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [PORTS-1:0]  req_i,
    output logic [PORTS-1:0]  gnt_oh_o,
    output logic [PIDX_W-1:0] gnt_idx_o,
    output logic              gnt_vld_o
);

    logic [PIDX_W-1:0] ptr_q, ptr_d;
    logic              found;
    int                cand;

    always_comb begin
        found     = 1'b0;
        cand      = 0;
        gnt_idx_o = '0;
        for (int i = 0; i < PORTS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= PORTS) cand = cand - PORTS;
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                gnt_idx_o = PIDX_W'(cand);
            end
        end
        gnt_vld_o = en_i && found;
        gnt_oh_o  = '0;
        if (gnt_vld_o) gnt_oh_o[gnt_idx_o] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_o) begin
            ptr_d = (gnt_idx_o == PIDX_W'(PORTS - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rx_drop_stat_sched.sv
// Per-port RX frame/drop counters: accumulators flushed round-robin into one shared RMW counter memory.
// Optional RX_DROP_STAT_SNAPSHOT_EN: a total read latches that port's drop count for a coherent pair.
module rx_drop_stat_sched
    import rx_drop_stat_pkg::*;
#(
    parameter int PORTS   = 2,
    parameter int REGIONS = 1,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [PORTS*REGIONS-1:0] ev_src_rdy_i,
    input  logic [PORTS*REGIONS-1:0] ev_eof_i,
    input  logic [PORTS*REGIONS-1:0] ev_drop_i,
    input  logic                     clr_i,
    output logic                     clr_busy_o,
    input  logic                     rd_req_i,
    input  logic [$clog2(PORTS):0]   rd_addr_i,
    output logic                     rd_ack_o,
    output logic                     rd_dvld_o,
    output logic [CNT_W-1:0]         rd_data_o,
    output logic                     acc_ovf_o
);

    localparam int PIDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int PC_W   = $clog2(REGIONS + 1);

    state_t            state_q, state_d;
    logic [PIDX_W-1:0] clr_idx_q, clr_idx_d;
    logic              clr_we;

    logic [PC_W-1:0]   frames [PORTS];
    logic [PC_W-1:0]   drops  [PORTS];
    logic [ACC_W-1:0]  acc_tot_q [PORTS];
    logic [ACC_W-1:0]  acc_tot_d [PORTS];
    logic [ACC_W-1:0]  acc_drp_q [PORTS];
    logic [ACC_W-1:0]  acc_drp_d [PORTS];
    logic [ACC_W:0]    sum_tot   [PORTS];
    logic [ACC_W:0]    sum_drp   [PORTS];
    logic              ovf_q, ovf_d, ovf_set;

    logic [PORTS-1:0]  req, gnt_oh;
    logic [PIDX_W-1:0] gnt_idx;
    logic              gnt_vld, sched_en;

    logic              s2_vld_q;
    logic [PIDX_W-1:0] s2_port_q;
    logic [CNT_W-1:0]  s2_base_tot_q, s2_base_drp_q;
    logic [ACC_W-1:0]  s2_amt_tot_q, s2_amt_drp_q;
    logic [CNT_W-1:0]  s2_sum_tot, s2_sum_drp;
    logic              s2_we, s1_fwd;
    logic [CNT_W-1:0]  s1_tot, s1_drp;

    logic [CNT_W-1:0]  mem_tot [PORTS];
    logic [CNT_W-1:0]  mem_drp [PORTS];

    logic [PIDX_W-1:0] rd_port;
    logic              rd_sel;
    logic [CNT_W-1:0]  rd_data_d, rd_data_q;
    logic              rd_dvld_q;

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            frames[p] = '0;
            drops[p]  = '0;
            for (int r = 0; r < REGIONS; r++) begin
                frames[p] = frames[p] + PC_W'(ev_src_rdy_i[p*REGIONS+r] & ev_eof_i[p*REGIONS+r]);
                drops[p]  = drops[p]  + PC_W'(ev_src_rdy_i[p*REGIONS+r] & ev_eof_i[p*REGIONS+r]
                                              & ev_drop_i[p*REGIONS+r]);
            end
        end
    end

    // A granted port hands its pending amount to S1 and restarts from this cycle's events.
    always_comb begin
        ovf_set = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            sum_tot[p] = {1'b0, (gnt_oh[p] ? '0 : acc_tot_q[p])} + (ACC_W+1)'(frames[p]);
            sum_drp[p] = {1'b0, (gnt_oh[p] ? '0 : acc_drp_q[p])} + (ACC_W+1)'(drops[p]);
            acc_tot_d[p] = sum_tot[p][ACC_W] ? '1 : sum_tot[p][ACC_W-1:0];
            acc_drp_d[p] = sum_drp[p][ACC_W] ? '1 : sum_drp[p][ACC_W-1:0];
            if (sum_tot[p][ACC_W] || sum_drp[p][ACC_W]) ovf_set = 1'b1;
            req[p] = (acc_tot_q[p] != '0) || (acc_drp_q[p] != '0);
        end
        ovf_d = ovf_set || (ovf_q && !clr_i);
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        case (state_q)
            RUN: begin
                if (clr_i) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_i) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == PIDX_W'(PORTS - 1)) begin
                    state_d = RUN;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign sched_en = (state_q == RUN) && !clr_i;

    rx_drop_rr_sched #(
        .PORTS  (PORTS),
        .PIDX_W (PIDX_W)
    ) u_sched (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (sched_en),
        .req_i     (req),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    // An S2 still in flight when the sweep starts is dropped; the sweep owns the write port.
    assign s2_we      = s2_vld_q && (state_q == RUN);
    assign s2_sum_tot = s2_base_tot_q + CNT_W'(s2_amt_tot_q);
    assign s2_sum_drp = s2_base_drp_q + CNT_W'(s2_amt_drp_q);
    assign s1_fwd     = s2_we && (s2_port_q == gnt_idx);
    assign s1_tot     = s1_fwd ? s2_sum_tot : mem_tot[gnt_idx];
    assign s1_drp     = s1_fwd ? s2_sum_drp : mem_drp[gnt_idx];

    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_tot[clr_idx_q] <= '0;
            mem_drp[clr_idx_q] <= '0;
        end else if (s2_we) begin
            mem_tot[s2_port_q] <= s2_sum_tot;
            mem_drp[s2_port_q] <= s2_sum_drp;
        end
    end

    assign rd_port  = PIDX_W'(rd_addr_i >> 1);
    assign rd_sel   = rd_addr_i[0];
    assign rd_ack_o = rd_req_i && (state_q == RUN) && !clr_i;

`ifdef RX_DROP_STAT_SNAPSHOT_EN
    logic [CNT_W-1:0]  snap_q;
    logic [PIDX_W-1:0] snap_port_q;
    logic              snap_vld_q;
    logic              snap_hit;

    assign snap_hit  = snap_vld_q && (snap_port_q == rd_port) && (rd_sel == SEL_DROP);
    assign rd_data_d = snap_hit ? snap_q
                     : ((rd_sel == SEL_DROP) ? mem_drp[rd_port] : mem_tot[rd_port]);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            snap_q      <= '0;
            snap_port_q <= '0;
            snap_vld_q  <= 1'b0;
        end else if (clr_i) begin
            snap_vld_q  <= 1'b0;
        end else if (rd_ack_o) begin
            if (rd_sel == SEL_TOTAL) begin
                snap_q      <= mem_drp[rd_port];
                snap_port_q <= rd_port;
                snap_vld_q  <= 1'b1;
            end else if (snap_hit) begin
                snap_vld_q  <= 1'b0;
            end
        end
    end
`else
    assign rd_data_d = (rd_sel == SEL_DROP) ? mem_drp[rd_port] : mem_tot[rd_port];
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= RUN;
            clr_idx_q     <= '0;
            ovf_q         <= 1'b0;
            s2_vld_q      <= 1'b0;
            s2_port_q     <= '0;
            s2_base_tot_q <= '0;
            s2_base_drp_q <= '0;
            s2_amt_tot_q  <= '0;
            s2_amt_drp_q  <= '0;
            rd_dvld_q     <= 1'b0;
            rd_data_q     <= '0;
            for (int p = 0; p < PORTS; p++) begin
                acc_tot_q[p] <= '0;
                acc_drp_q[p] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ovf_q     <= ovf_d;
            s2_vld_q  <= gnt_vld;
            if (gnt_vld) begin
                s2_port_q     <= gnt_idx;
                s2_base_tot_q <= s1_tot;
                s2_base_drp_q <= s1_drp;
                s2_amt_tot_q  <= acc_tot_q[gnt_idx];
                s2_amt_drp_q  <= acc_drp_q[gnt_idx];
            end
            rd_dvld_q <= rd_ack_o;
            if (rd_ack_o) rd_data_q <= rd_data_d;
            for (int p = 0; p < PORTS; p++) begin
                acc_tot_q[p] <= acc_tot_d[p];
                acc_drp_q[p] <= acc_drp_d[p];
            end
        end
    end

    assign clr_busy_o = (state_q == CLEAR);
    assign rd_dvld_o  = rd_dvld_q;
    assign rd_data_o  = rd_data_q;
    assign acc_ovf_o  = ovf_q;

endmodule

// File: tb/tb_rx_drop_stat_sched.sv
// Directed bench for rx_drop_stat_sched with default parameters (2 ports, 1 region, 48/8 bits).
module tb_rx_drop_stat_sched;
    import rx_drop_stat_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [1:0] ev_src_rdy_i, ev_eof_i, ev_drop_i;
    logic       clr_i, rd_req_i;
    logic [1:0] rd_addr_i;
    logic       clr_busy_o, rd_ack_o, rd_dvld_o, acc_ovf_o;
    cnt_t       rd_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    rx_drop_stat_sched dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .ev_src_rdy_i (ev_src_rdy_i),
        .ev_eof_i     (ev_eof_i),
        .ev_drop_i    (ev_drop_i),
        .clr_i        (clr_i),
        .clr_busy_o   (clr_busy_o),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_ack_o     (rd_ack_o),
        .rd_dvld_o    (rd_dvld_o),
        .rd_data_o    (rd_data_o),
        .acc_ovf_o    (acc_ovf_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [1:0] mask, input logic [1:0] drop, input int n);
        ev_src_rdy_i = mask;
        ev_eof_i     = mask;
        ev_drop_i    = drop;
        wait_cyc(n);
        ev_src_rdy_i = '0;
        ev_eof_i     = '0;
        ev_drop_i    = '0;
    endtask

    task automatic rd(input int port, input int sel, output cnt_t data);
        logic got;
        int   n;
        got       = 1'b0;
        n         = 0;
        rd_addr_i = 2'(port * 2 + sel);
        rd_req_i  = 1'b1;
        while (!got && n < 20) begin
            @(negedge clk_i);
            got = rd_ack_o;
            tick();
            n++;
        end
        rd_req_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (!got || rd_dvld_o !== 1'b1) begin
            errors++;
            $display("FAIL rd_handshake p%0d s%0d: ack=%0b dvld=%0b, required ack=1 dvld=1",
                     port, sel, got, rd_dvld_o);
        end
        data = rd_data_o;
        tick();
    endtask

    task automatic clear_all();
        int n;
        n     = 0;
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        while (clr_busy_o && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) begin
            checks++;
            errors++;
            $display("FAIL clear_timeout: busy still %0b after %0d cycles, required 0", clr_busy_o, n);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        ev_src_rdy_i = '0; ev_eof_i = '0; ev_drop_i = '0;
        clr_i = 1'b0; rd_req_i = 1'b0; rd_addr_i = '0;
        wait_cyc(3);
        @(negedge clk_i);
        checks += 5;
        if (clr_busy_o !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %0b, required 0", clr_busy_o); end
        if (rd_ack_o !== 1'b0)   begin errors++; $display("FAIL reset_rd_ack: got %0b, required 0", rd_ack_o); end
        if (rd_dvld_o !== 1'b0)  begin errors++; $display("FAIL reset_rd_dvld: got %0b, required 0", rd_dvld_o); end
        if (rd_data_o !== '0)    begin errors++; $display("FAIL reset_rd_data: got %0d, required 0", rd_data_o); end
        if (acc_ovf_o !== 1'b0)  begin errors++; $display("FAIL reset_acc_ovf: got %0b, required 0", acc_ovf_o); end
        tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_clr();
        int   n;
        cnt_t d;
        n     = 0;
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        while (n < 10) begin
            @(negedge clk_i);
            if (!clr_busy_o) break;
            n++;
            tick();
        end
        tick();
        checks++;
        if (n != 2) begin errors++; $display("FAIL clr_busy_len: got %0d cycles, required 2", n); end
        for (int a = 0; a < 4; a++) begin
            rd(a / 2, a % 2, d);
            checks++;
            if (d !== '0) begin errors++; $display("FAIL clr_zero p%0d s%0d: got %0d, required 0", a / 2, a % 2, d); end
        end
    endtask

    task automatic test_port0();
        cnt_t d;
        send(2'b01, 2'b01, 2);
        send(2'b01, 2'b00, 3);
        wait_cyc(3);
        rd(0, 0, d); checks++;
        if (d !== 48'd5) begin errors++; $display("FAIL port0_total: got %0d, required 5", d); end
        rd(0, 1, d); checks++;
        if (d !== 48'd2) begin errors++; $display("FAIL port0_drop: got %0d, required 2", d); end
        rd(1, 0, d); checks++;
        if (d !== 48'd0) begin errors++; $display("FAIL port1_total_idle: got %0d, required 0", d); end
        rd(1, 1, d); checks++;
        if (d !== 48'd0) begin errors++; $display("FAIL port1_drop_idle: got %0d, required 0", d); end
    endtask

    task automatic test_back_to_back();
        cnt_t d;
        logic exp_g;
        clear_all();
        exp_g = 1'b1;  // port0-only traffic before this left the pointer at port 1
        ev_src_rdy_i = 2'b11;
        ev_eof_i     = 2'b11;
        for (int i = 0; i < 110; i++) begin
            if (i == 100) begin
                ev_src_rdy_i = '0;
                ev_eof_i     = '0;
            end
            @(negedge clk_i);
            if (dut.gnt_vld) begin
                checks++;
                if (dut.gnt_idx !== exp_g) begin
                    errors++;
                    $display("FAIL rr_alternate cyc%0d: got grant %0d, required %0d", i, dut.gnt_idx, exp_g);
                end
                exp_g = ~exp_g;
            end
            tick();
        end
        rd(0, 0, d); checks++;
        if (d !== 48'd100) begin errors++; $display("FAIL b2b_total0: got %0d, required 100", d); end
        rd(1, 0, d); checks++;
        if (d !== 48'd100) begin errors++; $display("FAIL b2b_total1: got %0d, required 100", d); end
        checks++;
        if (acc_ovf_o !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %0b, required 0", acc_ovf_o); end
    endtask

    task automatic test_overflow();
        cnt_t d;
        clr_i        = 1'b1;
        ev_src_rdy_i = 2'b01;
        ev_eof_i     = 2'b01;
        wait_cyc(300);
        checks++;
        if (clr_busy_o !== 1'b1) begin errors++; $display("FAIL ovf_hold_busy: got %0b, required 1", clr_busy_o); end
        clr_i        = 1'b0;
        ev_src_rdy_i = '0;
        ev_eof_i     = '0;
        wait_cyc(6);
        rd(0, 0, d); checks++;
        if (d !== 48'd255) begin errors++; $display("FAIL ovf_saturate: got %0d, required 255", d); end
        checks++;
        if (acc_ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b, required 1", acc_ovf_o); end
        rd(1, 0, d); checks++;
        if (d !== 48'd0) begin errors++; $display("FAIL ovf_port1: got %0d, required 0", d); end
        clear_all();
        checks++;
        if (acc_ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b, required 0", acc_ovf_o); end
        rd(0, 0, d); checks++;
        if (d !== 48'd0) begin errors++; $display("FAIL ovf_cleared_total: got %0d, required 0", d); end
    endtask

    task automatic test_read_collision();
        cnt_t d;
        clear_all();
        send(2'b01, 2'b00, 7);
        wait_cyc(4);
        rd(0, 0, d); checks++;
        if (d !== 48'd7) begin errors++; $display("FAIL coll_setup: got %0d, required 7", d); end
        // One event: S1 in the next cycle, S2 writes 8 in the cycle the read is accepted.
        ev_src_rdy_i = 2'b01;
        ev_eof_i     = 2'b01;
        tick();
        ev_src_rdy_i = '0;
        ev_eof_i     = '0;
        tick();
        rd(0, 0, d); checks++;
        if (d !== 48'd7) begin errors++; $display("FAIL coll_pre_update: got %0d, required 7", d); end
        rd(0, 0, d); checks++;
        if (d !== 48'd8) begin errors++; $display("FAIL coll_post_update: got %0d, required 8", d); end
    endtask

    task automatic test_clr_vs_read();
        int n;
        n         = 0;
        clr_i     = 1'b1;
        rd_req_i  = 1'b1;
        rd_addr_i = 2'd0;
        @(negedge clk_i);
        checks++;
        if (rd_ack_o !== 1'b0) begin errors++; $display("FAIL clr_wins: rd_ack got %0b, required 0", rd_ack_o); end
        tick();
        clr_i = 1'b0;
        while (n < 10) begin
            @(negedge clk_i);
            if (rd_ack_o) break;
            n++;
            tick();
        end
        tick();
        rd_req_i = 1'b0;
        checks++;
        if (n != 2) begin errors++; $display("FAIL rd_wait_busy: waited %0d cycles, required 2", n); end
        @(negedge clk_i);
        checks++;
        if (rd_dvld_o !== 1'b1 || rd_data_o !== '0) begin
            errors++;
            $display("FAIL rd_after_clr: dvld=%0b data=%0d, required dvld=1 data=0", rd_dvld_o, rd_data_o);
        end
        tick();
    endtask

`ifdef RX_DROP_STAT_SNAPSHOT_EN
    task automatic test_snapshot();
        cnt_t d;
        clear_all();
        send(2'b01, 2'b01, 3);
        send(2'b01, 2'b00, 7);
        wait_cyc(4);
        rd(0, 0, d); checks++;
        if (d !== 48'd10) begin errors++; $display("FAIL snap_total: got %0d, required 10", d); end
        send(2'b01, 2'b01, 4);
        wait_cyc(4);
        rd(0, 1, d); checks++;
        if (d !== 48'd3) begin errors++; $display("FAIL snap_drop: got %0d, required 3", d); end
        rd(0, 1, d); checks++;
        if (d !== 48'd7) begin errors++; $display("FAIL snap_live_drop: got %0d, required 7", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_clr();
        test_port0();
        test_back_to_back();
        test_overflow();
        test_read_collision();
        test_clr_vs_read();
`ifdef RX_DROP_STAT_SNAPSHOT_EN
        test_snapshot();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule
